// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y counters, sync/active decode and frame/line markers.
// All outputs are registered from the next-state counters, so they stay mutually coherent.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        en,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        active_video_o,
    output logic        frame_start_o,
    output logic        line_start_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        running_o,
    output logic [15:0] frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 4096");
    end

    // 13-bit bounds so a 4096-wide region compares correctly against 12-bit counters.
    localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q;
    logic [0:0]  nx_state;
    logic [11:0] nx_x;
    logic [11:0] nx_y;
    logic        nx_run;
    logic        nx_frame_start;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        nx_state = state_q;
        nx_x     = x_o;
        nx_y     = y_o;
        if (state_q == ST_IDLE) begin
            if (en) nx_state = ST_RUN;
        end else if (x_o == H_LAST) begin
            nx_x = '0;
            if (y_o == V_LAST) begin
                nx_y = '0;
                // en only matters at the final cycle of the frame.
                if (!en) nx_state = ST_IDLE;
            end else begin
                nx_y = y_o + 12'd1;
            end
        end else begin
            nx_x = x_o + 12'd1;
        end
        nx_run         = (nx_state == ST_RUN);
        nx_frame_start = nx_run && (nx_x == '0) && (nx_y == '0);
    end

    assign running_o = (state_q == ST_RUN);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q        <= ST_IDLE;
            x_o            <= '0;
            y_o            <= '0;
            active_video_o <= 1'b0;
            frame_start_o  <= 1'b0;
            line_start_o   <= 1'b0;
            hsync_o        <= ~HSYNC_POL;
            vsync_o        <= ~VSYNC_POL;
            frame_cnt_o    <= '0;
        end else begin
            state_q        <= nx_state;
            x_o            <= nx_x;
            y_o            <= nx_y;
            active_video_o <= nx_run && ({1'b0, nx_x} < H_ACT_END) && ({1'b0, nx_y} < V_ACT_END);
            frame_start_o  <= nx_frame_start;
            line_start_o   <= nx_run && (nx_x == '0);
            hsync_o        <= (nx_run && ({1'b0, nx_x} >= H_SYNC_BEG) && ({1'b0, nx_x} < H_SYNC_END))
                              ? HSYNC_POL : ~HSYNC_POL;
            vsync_o        <= (nx_run && ({1'b0, nx_y} >= V_SYNC_BEG) && ({1'b0, nx_y} < V_SYNC_END))
                              ? VSYNC_POL : ~VSYNC_POL;
            if (nx_frame_start) frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x8 raster (H 8/2/2/4, V 4/1/1/2, active-low syncs).
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        srst;
    logic        en;
    logic        hsync_o;
    logic        vsync_o;
    logic        active_video_o;
    logic        frame_start_o;
    logic        line_start_o;
    logic [11:0] x_o;
    logic [11:0] y_o;
    logic        running_o;
    logic [15:0] frame_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .srst(srst), .en(en),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .active_video_o(active_video_o),
        .frame_start_o(frame_start_o), .line_start_o(line_start_o),
        .x_o(x_o), .y_o(y_o), .running_o(running_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        en   = 1'b0;
        step();
        srst = 1'b0;
    endtask

    // Idle snapshot: {x, y, running, av, hs, vs, fs, ls}.
    function automatic logic [29:0] idle_snap();
        return {x_o, y_o, running_o, active_video_o, hsync_o, vsync_o, frame_start_o, line_start_o};
    endfunction

    localparam logic [29:0] IDLE_EXP = {12'd0, 12'd0, 6'b001100};

    // Checks one full frame cycle-by-cycle; entry point is the sampled first cycle.
    // en is dropped before the edge that ends cycle index drop_idx (-1 = never).
    task automatic run_frame(input string name, input int drop_idx, input logic [15:0] exp_cnt,
                             output int av_cnt, output int av_runs);
        logic [45:0] got;
        logic [45:0] exp;
        logic        prev_av;
        int          ex;
        int          ey;
        av_cnt  = 0;
        av_runs = 0;
        prev_av = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ex  = i % 16;
            ey  = i / 16;
            got = {x_o, y_o, running_o, active_video_o, hsync_o, vsync_o,
                   frame_start_o, line_start_o, frame_cnt_o};
            exp = {12'(ex), 12'(ey), 1'b1,
                   (ex < 8 && ey < 4),
                   !(ex >= 10 && ex < 12),
                   !(ey == 5),
                   (i == 0),
                   (ex == 0),
                   exp_cnt};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, exp);
            end
            if (active_video_o === 1'b1) av_cnt++;
            if (active_video_o === 1'b1 && prev_av !== 1'b1) av_runs++;
            prev_av = active_video_o;
            if (i == drop_idx) en = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        en   = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (idle_snap() !== IDLE_EXP || frame_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL reset_values: got %h/%h expected %h/0000", idle_snap(), frame_cnt_o, IDLE_EXP);
        end
        srst = 1'b0;
        step();
        n_cmp++;
        if (idle_snap() !== IDLE_EXP) begin
            n_err++;
            $display("FAIL reset_idle_hold: got %h expected %h", idle_snap(), IDLE_EXP);
        end
    endtask

    task automatic test_reset_priority();
        srst = 1'b1;
        en   = 1'b1;
        repeat (2) step();
        n_cmp++;
        if (running_o !== 1'b0 || frame_start_o !== 1'b0) begin
            n_err++;
            $display("FAIL srst_over_en: got running=%b fs=%b expected 0 0", running_o, frame_start_o);
        end
        srst = 1'b0;
        step();
        n_cmp++;
        if (running_o !== 1'b1 || frame_start_o !== 1'b1 || frame_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL run_after_srst: got running=%b fs=%b cnt=%0d expected 1 1 1",
                     running_o, frame_start_o, frame_cnt_o);
        end
        en = 1'b0;
    endtask

    task automatic test_single_frame();
        int av_cnt;
        int av_runs;
        do_reset();
        en = 1'b1;
        step();
        en = 1'b0;
        run_frame("single_frame", -1, 16'd1, av_cnt, av_runs);
        n_cmp++;
        if (av_cnt != 32 || av_runs != 4) begin
            n_err++;
            $display("FAIL single_av_count: got %0d in %0d runs expected 32 in 4 runs", av_cnt, av_runs);
        end
        n_cmp++;
        if (idle_snap() !== IDLE_EXP || frame_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL single_idle_at_129: got %h cnt=%0d expected %h cnt=1",
                     idle_snap(), frame_cnt_o, IDLE_EXP);
        end
    endtask

    task automatic test_back_to_back();
        int av_cnt;
        int av_runs;
        do_reset();
        en = 1'b1;
        step();
        run_frame("continuous_f1", -1, 16'd1, av_cnt, av_runs);
        run_frame("continuous_f2", -1, 16'd2, av_cnt, av_runs);
        run_frame("continuous_f3", 127, 16'd3, av_cnt, av_runs);
        n_cmp++;
        if (idle_snap() !== IDLE_EXP || frame_cnt_o !== 16'd3) begin
            n_err++;
            $display("FAIL continuous_stop: got %h cnt=%0d expected %h cnt=3",
                     idle_snap(), frame_cnt_o, IDLE_EXP);
        end
        // Minimum-gap restart: en high in the first idle cycle starts RUN on the next.
        en = 1'b1;
        step();
        n_cmp++;
        if (running_o !== 1'b1 || frame_start_o !== 1'b1 || active_video_o !== 1'b1 || frame_cnt_o !== 16'd4) begin
            n_err++;
            $display("FAIL restart_gap: got running=%b fs=%b av=%b cnt=%0d expected 1 1 1 4",
                     running_o, frame_start_o, active_video_o, frame_cnt_o);
        end
        en = 1'b0;
    endtask

    task automatic test_late_disable();
        int av_cnt;
        int av_runs;
        do_reset();
        en = 1'b1;
        step();
        run_frame("late_disable", 2 * 16 + 5, 16'd1, av_cnt, av_runs);
        n_cmp++;
        if (av_cnt != 32) begin
            n_err++;
            $display("FAIL late_disable_av: got %0d expected 32", av_cnt);
        end
        n_cmp++;
        if (idle_snap() !== IDLE_EXP) begin
            n_err++;
            $display("FAIL late_disable_idle: got %h expected %h", idle_snap(), IDLE_EXP);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        en = 1'b1;
        step();
        repeat (19) step();
        n_cmp++;
        if (x_o !== 12'd3 || y_o !== 12'd1) begin
            n_err++;
            $display("FAIL mid_reset_position: got (%0d,%0d) expected (3,1)", x_o, y_o);
        end
        srst = 1'b1;
        step();
        srst = 1'b0;
        n_cmp++;
        if (idle_snap() !== IDLE_EXP || frame_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset_abort: got %h cnt=%0d expected %h cnt=0",
                     idle_snap(), frame_cnt_o, IDLE_EXP);
        end
        step();
        n_cmp++;
        if (frame_start_o !== 1'b1 || frame_cnt_o !== 16'd1 || running_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_restart: got fs=%b cnt=%0d running=%b expected 1 1 1",
                     frame_start_o, frame_cnt_o, running_o);
        end
        en = 1'b0;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        step();
        force dut.frame_cnt_o = 16'hFFFF;
        step();
        release dut.frame_cnt_o;
        step();
        en = 1'b1;
        step();
        en = 1'b0;
        n_cmp++;
        if (frame_start_o !== 1'b1 || frame_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL counter_wrap: got fs=%b cnt=%0d expected fs=1 cnt=0", frame_start_o, frame_cnt_o);
        end
    endtask

    initial begin
        srst = 1'b1;
        en   = 1'b0;
        test_reset();
        test_reset_priority();
        test_single_frame();
        test_back_to_back();
        test_late_disable();
        test_mid_reset();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates VGA raster timing for the display output path: horizontal/vertical sync, active-video strobe, pixel coordinates and frame/line markers.
- `active_video_o` drives the read-enable of the downstream AXI-stream-to-VGA buffer. That buffer pops one 24-bit pixel per active cycle.
- Frames start and stop only on frame boundaries, so the buffer is never drained mid-frame.

## Interface

Parameters:
- `H_ACTIVE`, 640 — visible pixels per line
- `H_FP`, 16 — horizontal front porch, cycles
- `H_SYNC`, 96 — hsync pulse width, cycles
- `H_BP`, 48 — horizontal back porch, cycles
- `V_ACTIVE`, 480 — visible lines per frame
- `V_FP`, 10 — vertical front porch, lines
- `V_SYNC`, 2 — vsync width, lines
- `V_BP`, 33 — vertical back porch, lines
- `HSYNC_POL`, 0 — asserted level of `hsync_o`
- `VSYNC_POL`, 0 — asserted level of `vsync_o`

Ports:
- `clk` — in, 1 — pixel clock; the single clock of the block.
- `srst` — in, 1 — synchronous, active-high reset.
- `en` — in, 1 — run request; sampled only in IDLE and at the last cycle of a frame.
- `hsync_o` — out, 1 — horizontal sync.
- `vsync_o` — out, 1 — vertical sync.
- `active_video_o` — out, 1 — visible-pixel strobe (FIFO read enable downstream).
- `frame_start_o` — out, 1 — 1-cycle pulse at pixel (0,0).
- `line_start_o` — out, 1 — 1-cycle pulse at x=0 of every line, including blanking lines.
- `x_o` — out, 12 — current horizontal count.
- `y_o` — out, 12 — current vertical count.
- `running_o` — out, 1 — high while in RUN.
- `frame_cnt_o` — out, 16 — frames started since reset; wraps at 65535 -> 0.

## Operation

Derived totals:
- `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP`; `V_TOTAL` defined likewise.
- Both totals must be ≤ 4096. Elaboration-time check fails otherwise.
- Each line is ordered: active, front porch, sync, back porch. Each frame follows the same order in lines.

States:
- IDLE:
  - Counters held at (0,0).
  - All outputs are at their inactive levels.
  - `en`=1 moves to RUN.
- RUN:
  - `x` counts 0..`H_TOTAL`-1, then wraps to 0 and increments `y`.
  - `y` counts 0..`V_TOTAL`-1.
  - At (`H_TOTAL`-1, `V_TOTAL`-1):
    - `en`=1: wrap to (0,0) and start the next frame with no gap.
    - `en`=0: go to IDLE.
  - `en` deasserting mid-frame has no effect until the frame ends.

Output decode (all outputs registered and mutually coherent; values below hold in the same cycle as `x_o`/`y_o`):
- `active_video_o` = RUN & `x`<`H_ACTIVE` & `y`<`V_ACTIVE`.
- `hsync_o` is at `HSYNC_POL` when RUN & `H_ACTIVE`+`H_FP` ≤ `x` < `H_ACTIVE`+`H_FP`+`H_SYNC`; else `~HSYNC_POL`.
- `vsync_o` is at `VSYNC_POL` when RUN & `V_ACTIVE`+`V_FP` ≤ `y` < `V_ACTIVE`+`V_FP`+`V_SYNC`; else `~VSYNC_POL`. Each asserted line is asserted for the whole line.
- `frame_start_o` = RUN & `x`=0 & `y`=0.
- `line_start_o` = RUN & `x`=0.
- `frame_cnt_o` increments in the same cycle `frame_start_o` is high. The first frame after reset shows 1.

## Timing

Reset values (cycle after `srst` is sampled high):
- State IDLE.
- `x_o`=0, `y_o`=0.
- `active_video_o`, `frame_start_o`, `line_start_o`, `running_o` = 0.
- `hsync_o`=`~HSYNC_POL`, `vsync_o`=`~VSYNC_POL`.
- `frame_cnt_o`=0.

Latency and gaps:
- `en` sampled high in IDLE at cycle N: at cycle N+1, `running_o`=1, (0,0), `active_video_o`=1 and `frame_start_o`=1.
- Stop, then restart: last frame cycle at T with `en`=0 → IDLE at T+1. `en`=1 at T+1 → RUN at T+2. The minimum gap is one idle cycle.
- Back-to-back frames with `en` held high: exactly `H_TOTAL`×`V_TOTAL` cycles between `frame_start_o` pulses.

Reset and enable edge cases:
- `srst` mid-frame aborts immediately. Reset values appear the next cycle whatever `en` is, and `srst` overrides `en`.
- `srst` and `en` both high: reset wins. RUN begins one cycle after the first cycle with `srst`=0 & `en`=1.

## Test plan

All scenarios use H=8/2/2/4 (`H_TOTAL` 16), V=4/1/1/2 (`V_TOTAL` 8), both polarities 0; one frame is 128 cycles.

- **Reset:** hold `srst` 3 cycles → all reset values above; `hsync_o`=`vsync_o`=1.
- **Single frame:** `en`=1 for one cycle, then 0 → exactly one frame.
  - `active_video_o` high for 32 cycles in 4 runs of 8.
  - `hsync_o` low at x=10..11 on all 8 lines.
  - `vsync_o` low for all 16 cycles of y=5.
  - `frame_cnt_o`=1; IDLE at cycle 129 after start.
- **Continuous:** `en` held high for 3 frames.
  - `frame_start_o` at cycles 1, 129, 257.
  - `frame_cnt_o` reaches 3.
  - No idle cycle between frames.
- **Late disable:** `en` dropped at (x=5, y=2) → frame completes to (15,7), then IDLE; `active_video_o` count for the frame is 32.
- **Mid-frame reset:** `srst` pulsed at (3,1) with `en`=1 → next cycle x=y=0, `running_o`=0. The cycle after `srst` falls shows `frame_start_o`=1 and `frame_cnt_o`=1.
- **Counter wrap:** force `frame_cnt_o` to 65535 via 65535 frames, or via a bench `force` → the next frame start shows 0.
